maxpool_scheduler: RTL and testbench
====================================

// Module: maxpool_scheduler
// PURPOSE
//  Sequences 2x2/stride-2 max pooling over one conv feature map held in a 4-read-port sync RAM.
//  Walks windows in raster order, fetches the 4 pixels, hands them to the pooling datapath,
//  then writes each result to the pooled-map RAM. Sits between the conv output buffer and the dense layer.
// PARAMETERS
//  IMG_W      26  conv map width (pixels)
//  IMG_H      26  conv map height (pixels)
//  DATA_W     8   signed pixel width
//  ADDR_W     10  conv RAM address width
//  OUT_ADDR_W 8   pooled RAM address width
// PORTS
//  clk        in  1           single clock, all logic on posedge
//  rst        in  1           synchronous, active-low reset
//  start      in  1           1-cycle pulse: begin one map pass
//  busy       out 1           high from start accept until done
//  done       out 1           1-cycle pulse after last write
//  rd_addr0-3 out ADDR_W      window addrs: TL, TR, BL, BR
//  rd_data0-3 in  DATA_W      RAM data, valid 1 cycle after rd_addr
//  pool_a-d   out DATA_W      captured window pixels to pooling datapath
//  pool_start out 1           1-cycle pulse: pool_a-d valid
//  pool_done  in  1           datapath result valid (any latency >=1)
//  pool_max   in  DATA_W      datapath result
//  wr_en      out 1           pooled RAM write request
//  wr_addr    out OUT_ADDR_W  pooled address = r*(IMG_W/2)+c
//  wr_data    out DATA_W      pooled value
//  wr_ready   in  1           write accepted when wr_en&wr_ready
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state IDLE; all outputs 0; counters 0. Reset mid-pass aborts, no done.
//  - States: IDLE -> FETCH -> WAIT_RD -> POOL -> WAIT_POOL -> WRITE -> (ADVANCE -> FETCH | DONE) -> IDLE.
//  - IDLE: start=1 -> FETCH, busy=1 next cycle. start while busy ignored.
//  - FETCH: drive rd_addr0=base, 1=base+1, 2=base+IMG_W, 3=base+IMG_W+1; base=2r*IMG_W+2c.
//  - WAIT_RD: register rd_data0-3 into pool_a-d (held until next FETCH).
//  - POOL: pool_start=1 for exactly one cycle.
//  - WAIT_POOL: hold until pool_done; latch pool_max. pool_done outside WAIT_POOL ignored.
//  - WRITE: wr_en=1, wr_addr/wr_data stable until wr_ready; leave on wr_en&wr_ready. wr_ready low = stall, no drop.
//  - ADVANCE: c++; at c=IMG_W/2-1 wrap c=0, r++; after r=IMG_H/2-1,c=IMG_W/2-1 -> DONE.
//  - DONE: done=1 one cycle, busy=0 same cycle, -> IDLE.
//  - Odd IMG_W/IMG_H: floor; last column/row never read.
//  - base tracked incrementally (+2 per col, +IMG_W+2 on row wrap, net 2*IMG_W per row); no multiplier.
//  - Min cycles/window: 5 + pool latency; write accepted same cycle wr_ready=1.
//  - Values signed two's complement; scheduler does no arithmetic on data except optional clamp.
// CONFIGURATION
//  MAXPOOL_RELU_EN defined: wr_data = (pool_max<0) ? 0 : pool_max (fused ReLU).
//  Undefined: wr_data = pool_max unmodified. Timing identical both ways.
// STRUCTURE
//  maxpool_pkg: state encoding localparams, POOL_W=IMG_W/2, POOL_H=IMG_H/2, window count.
//  Sub-module maxpool_addr_gen: r/c counters, base/out address, last-window flag; FSM in top.
// TESTING
//  1 4x4 map 0..15, pool_done 1 cycle after pool_start -> writes (0,5),(1,7),(2,13),(3,15), one done.
//  2 All-negative 4x4 (-8..-1 style) -> signed max per window; with MAXPOOL_RELU_EN all writes 0.
//  3 wr_ready low 3 cycles on window 1 -> wr_en/addr/data stable 4 cycles, no lost/duplicate writes.
//  4 5x5 map -> exactly 4 writes, row 4/col 4 addresses never driven.
//  5 rst=0 during WAIT_POOL of window 2 -> next cycle all outputs 0, IDLE; new start gives full pass.
//  6 start pulsed while busy, pool_done pulsed in IDLE -> ignored; write count still POOL_W*POOL_H.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool scheduler: default geometry,
// FSM state encoding and pooled-map dimension helpers.
package maxpool_pkg;

  localparam int IMG_W_DEF      = 26;
  localparam int IMG_H_DEF      = 26;
  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 10;
  localparam int OUT_ADDR_W_DEF = 8;

  localparam int POOL_W    = IMG_W_DEF / 2;
  localparam int POOL_H    = IMG_H_DEF / 2;
  localparam int WIN_COUNT = POOL_W * POOL_H;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_RD   = 3'd2,
    S_POOL      = 3'd3,
    S_WAIT_POOL = 3'd4,
    S_WRITE     = 3'd5,
    S_ADVANCE   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  // Odd dimensions floor: the trailing row/column is never pooled.
  function automatic int pool_dim(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Window walker: row/column counters, incrementally tracked top-left conv address,
// pooled output address and last-window flag. No multiplier anywhere.
module maxpool_addr_gen
  import maxpool_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int OUT_ADDR_W = OUT_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  output logic [ADDR_W-1:0]     base,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic                  last
);

  localparam int PW = pool_dim(IMG_W);
  localparam int PH = pool_dim(IMG_H);
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam int RW = (PH > 1) ? $clog2(PH) : 1;
  // From the last window of a row to the first of the next; skips the unread odd column.
  localparam int ROW_STEP = 2 * IMG_W - 2 * (PW - 1);

  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic          c_last;

  assign c_last = (c == CW'(PW - 1));
  assign last   = c_last && (r == RW'(PH - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      c        <= '0;
      r        <= '0;
      base     <= '0;
      out_addr <= '0;
    end else if (step) begin
      out_addr <= out_addr + OUT_ADDR_W'(1);
      if (c_last) begin
        c    <= '0;
        r    <= r + RW'(1);
        base <= base + ADDR_W'(ROW_STEP);
      end else begin
        c    <= c + CW'(1);
        base <= base + ADDR_W'(2);
      end
    end
  end

endmodule

// File: rtl/maxpool_scheduler.sv
// 2x2/stride-2 max-pool sequencer: fetch window, hand to datapath, write result.
// Optional MAXPOOL_RELU_EN clamps negative results to zero before the write.
module maxpool_scheduler
  import maxpool_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int OUT_ADDR_W = OUT_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     rd_addr0,
  output logic [ADDR_W-1:0]     rd_addr1,
  output logic [ADDR_W-1:0]     rd_addr2,
  output logic [ADDR_W-1:0]     rd_addr3,
  input  logic [DATA_W-1:0]     rd_data0,
  input  logic [DATA_W-1:0]     rd_data1,
  input  logic [DATA_W-1:0]     rd_data2,
  input  logic [DATA_W-1:0]     rd_data3,
  output logic [DATA_W-1:0]     pool_a,
  output logic [DATA_W-1:0]     pool_b,
  output logic [DATA_W-1:0]     pool_c,
  output logic [DATA_W-1:0]     pool_d,
  output logic                  pool_start,
  input  logic                  pool_done,
  input  logic [DATA_W-1:0]     pool_max,
  output logic                  wr_en,
  output logic [OUT_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_ready
);

  state_t                  state, state_nx;
  logic [ADDR_W-1:0]       base;
  logic [OUT_ADDR_W-1:0]   out_addr;
  logic                    last;
  logic                    clear, step;
  logic [DATA_W-1:0]       res, res_nx;

  maxpool_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .OUT_ADDR_W(OUT_ADDR_W)
  ) u_addr_gen (
    .clk(clk), .rst(rst), .clear(clear), .step(step),
    .base(base), .out_addr(out_addr), .last(last)
  );

`ifdef MAXPOOL_RELU_EN
  assign res_nx = pool_max[DATA_W-1] ? '0 : pool_max;
`else
  assign res_nx = pool_max;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      pool_a <= '0;
      pool_b <= '0;
      pool_c <= '0;
      pool_d <= '0;
      res    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT_RD) begin
        pool_a <= rd_data0;
        pool_b <= rd_data1;
        pool_c <= rd_data2;
        pool_d <= rd_data3;
      end
      if (state == S_WAIT_POOL && pool_done) res <= res_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start) state_nx = S_FETCH;
      S_FETCH:     state_nx = S_WAIT_RD;
      S_WAIT_RD:   state_nx = S_POOL;
      S_POOL:      state_nx = S_WAIT_POOL;
      S_WAIT_POOL: if (pool_done) state_nx = S_WRITE;
      S_WRITE:     if (wr_ready) state_nx = S_ADVANCE;
      S_ADVANCE:   state_nx = last ? S_DONE : S_FETCH;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Counters clear on accepted start so an aborted pass never leaks its position.
  assign clear = (state == S_IDLE) && start;
  assign step  = (state == S_ADVANCE) && !last;

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign pool_start = (state == S_POOL);
  assign wr_en      = (state == S_WRITE);
  assign wr_addr    = wr_en ? out_addr : '0;
  assign wr_data    = wr_en ? res : '0;

  assign rd_addr0 = (state == S_FETCH) ? base                          : '0;
  assign rd_addr1 = (state == S_FETCH) ? base + ADDR_W'(1)             : '0;
  assign rd_addr2 = (state == S_FETCH) ? base + ADDR_W'(IMG_W)         : '0;
  assign rd_addr3 = (state == S_FETCH) ? base + ADDR_W'(IMG_W + 1)     : '0;

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Bench for maxpool_scheduler: a 4x4 and a 5x5 instance, behavioural RAM and pooling
// datapath, expected pooled map computed directly from the conv map contents.
module tb_maxpool_scheduler;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start[2], busy[2], done[2], pool_start[2], pool_done[2], wr_en[2], wr_ready[2];
  logic [AW-1:0] rd_addr[2][4];
  logic [DW-1:0] rd_data[2][4], pool_v[2][4], pool_max[2], wr_data[2];
  logic [OW-1:0] wr_addr[2];
  logic signed [DW-1:0] mem[2][1024];

  int            cnt[2]       = '{0, 0};
  logic [DW-1:0] pmax[2];
  int            lat_fix[2]   = '{1, 1};
  int            stall_pct[2] = '{0, 0};
  bit            force_stall[2] = '{0, 0};
  int            hold_cnt[2]  = '{0, 0};
  bit            rnd_rdy[2]   = '{1, 1};
  bit            noise[2]     = '{0, 0};
  logic [DW-1:0] noise_val    = 8'h55;

  int checks = 0, failures = 0;
  int got_a[$], got_d[$];
  int done_cnt[2] = '{0, 0};
  int ps_cnt[2]   = '{0, 0};
  int win1_cyc = 0, bad_addr = 0;
  bit prev_stall[2] = '{0, 0};
  int prev_addr[2], prev_data[2];

  maxpool_scheduler #(.IMG_W(4), .IMG_H(4), .DATA_W(DW), .ADDR_W(AW), .OUT_ADDR_W(OW)) u4 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .rd_addr0(rd_addr[0][0]), .rd_addr1(rd_addr[0][1]), .rd_addr2(rd_addr[0][2]), .rd_addr3(rd_addr[0][3]),
    .rd_data0(rd_data[0][0]), .rd_data1(rd_data[0][1]), .rd_data2(rd_data[0][2]), .rd_data3(rd_data[0][3]),
    .pool_a(pool_v[0][0]), .pool_b(pool_v[0][1]), .pool_c(pool_v[0][2]), .pool_d(pool_v[0][3]),
    .pool_start(pool_start[0]), .pool_done(pool_done[0]), .pool_max(pool_max[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ready(wr_ready[0])
  );

  maxpool_scheduler #(.IMG_W(5), .IMG_H(5), .DATA_W(DW), .ADDR_W(AW), .OUT_ADDR_W(OW)) u5 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .rd_addr0(rd_addr[1][0]), .rd_addr1(rd_addr[1][1]), .rd_addr2(rd_addr[1][2]), .rd_addr3(rd_addr[1][3]),
    .rd_data0(rd_data[1][0]), .rd_data1(rd_data[1][1]), .rd_data2(rd_data[1][2]), .rd_data3(rd_data[1][3]),
    .pool_a(pool_v[1][0]), .pool_b(pool_v[1][1]), .pool_c(pool_v[1][2]), .pool_d(pool_v[1][3]),
    .pool_start(pool_start[1]), .pool_done(pool_done[1]), .pool_max(pool_max[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ready(wr_ready[1])
  );

  function automatic int iw(input int g);
    return (g == 0) ? 4 : 5;
  endfunction

  function automatic logic [DW-1:0] max4(input logic signed [DW-1:0] a, b, c, d);
    logic signed [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // RAM (1-cycle read), pooling datapath with programmable latency, write-ready source.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) rd_data[g][k] <= mem[g][rd_addr[g][k]];
      if (pool_start[g]) begin
        cnt[g]  <= (lat_fix[g] > 0) ? lat_fix[g] : int'($urandom_range(1, 3));
        pmax[g] <= max4(pool_v[g][0], pool_v[g][1], pool_v[g][2], pool_v[g][3]);
      end else if (cnt[g] > 0) begin
        cnt[g] <= cnt[g] - 1;
      end
      rnd_rdy[g] <= (int'($urandom_range(0, 99)) >= stall_pct[g]);
      if (!force_stall[g]) hold_cnt[g] <= 0;
      else if (wr_en[g] && wr_addr[g] == OW'(1) && !wr_ready[g]) hold_cnt[g] <= hold_cnt[g] + 1;
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      pool_done[g] = (cnt[g] == 1) || noise[g];
      pool_max[g]  = (cnt[g] == 1) ? pmax[g] : noise_val;
      wr_ready[g]  = rnd_rdy[g] &&
                     !(force_stall[g] && hold_cnt[g] < 3 && wr_en[g] && wr_addr[g] == OW'(1));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int outs_nz(input int g);
    int acc;
    acc = int'(busy[g]) | int'(done[g]) | int'(pool_start[g]) | int'(wr_en[g]) |
          int'(wr_addr[g]) | int'(wr_data[g]);
    for (int k = 0; k < 4; k++) acc = acc | int'(rd_addr[g][k]) | int'(pool_v[g][k]);
    return acc;
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wr_en[g] && wr_ready[g]) begin
        got_a.push_back(int'(wr_addr[g]));
        got_d.push_back(int'($signed(wr_data[g])));
      end
      if (prev_stall[g] && rst) begin
        chk("wr_hold_en", int'(wr_en[g]), 1);
        chk("wr_hold_addr", int'(wr_addr[g]), prev_addr[g]);
        chk("wr_hold_data", int'(wr_data[g]), prev_data[g]);
      end
      prev_stall[g] = wr_en[g] && !wr_ready[g];
      prev_addr[g]  = int'(wr_addr[g]);
      prev_data[g]  = int'(wr_data[g]);
      if (done[g]) begin
        done_cnt[g]++;
        chk("done_busy_low", int'(busy[g]), 0);
      end
      if (pool_start[g]) ps_cnt[g]++;
    end
    if (wr_en[0] && wr_addr[0] == OW'(1)) win1_cyc++;
    if (busy[1])
      for (int k = 0; k < 4; k++)
        if (int'(rd_addr[1][k]) % 5 == 4 || int'(rd_addr[1][k]) >= 20) bad_addr++;
  end

  task automatic run_pass(input int g, input string tag, input bit extra, output int n0);
    int d0, cyc, w, ne;
    int exp_a[$], exp_d[$];
    n0 = got_a.size();
    d0 = done_cnt[g];
    @(negedge clk) start[g] = 1'b1;
    @(negedge clk) start[g] = 1'b0;
    chk({tag, "_busy"}, int'(busy[g]), 1);
    if (extra) begin
      repeat (4) @(negedge clk);
      start[g] = 1'b1;
      @(negedge clk) start[g] = 1'b0;
      repeat (9) @(negedge clk);
      start[g] = 1'b1;
      @(negedge clk) start[g] = 1'b0;
    end
    cyc = 0;
    while (done_cnt[g] == d0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt[g] - d0, 1);
    chk({tag, "_idle_after"}, int'(busy[g]), 0);
    w = iw(g);
    for (int r = 0; r < w / 2; r++)
      for (int c = 0; c < w / 2; c++) begin
        int b, m;
        b = 2 * r * w + 2 * c;
        m = int'(mem[g][b]);
        if (int'(mem[g][b + 1]) > m) m = int'(mem[g][b + 1]);
        if (int'(mem[g][b + w]) > m) m = int'(mem[g][b + w]);
        if (int'(mem[g][b + w + 1]) > m) m = int'(mem[g][b + w + 1]);
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        exp_a.push_back(r * (w / 2) + c);
        exp_d.push_back(m);
      end
    ne = got_a.size() - n0;
    chk({tag, "_write_count"}, ne, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < ne; i++) begin
      chk({tag, "_wr_addr"}, got_a[n0 + i], exp_a[i]);
      chk({tag, "_wr_data"}, got_d[n0 + i], exp_d[i]);
    end
  endtask

  task automatic fill_rand(input int g, input int lo, input int hi);
    for (int i = 0; i < 1024; i++) mem[g][i] = DW'($urandom_range(lo, hi) - 128);
  endtask

  initial begin
    int n0, p0, d0, w0, cyc;
    rst = 1'b0;
    start = '{1'b0, 1'b0};
    for (int i = 0; i < 1024; i++) begin
      mem[0][i] = '0;
      mem[1][i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outs_u4", outs_nz(0), 0);
    chk("reset_outs_u5", outs_nz(1), 0);
    rst = 1'b1;
    @(negedge clk);

    // 4x4 ramp, latency 1
    for (int i = 0; i < 16; i++) mem[0][i] = DW'(i);
    lat_fix[0] = 1;
    run_pass(0, "t1", 1'b0, n0);
    if (got_a.size() >= n0 + 4) begin
      chk("t1_w0", got_d[n0], 5);
      chk("t1_w1", got_d[n0 + 1], 7);
      chk("t1_w2", got_d[n0 + 2], 13);
      chk("t1_w3", got_d[n0 + 3], 15);
    end else chk("t1_have_4_writes", got_a.size() - n0, 4);

    // all-negative map
    fill_rand(0, 0, 127);
    lat_fix[0] = 2;
    run_pass(0, "t2", 1'b0, n0);

    // window 1 write stalled 3 cycles
    fill_rand(0, 0, 255);
    stall_pct[0]   = 0;
    force_stall[0] = 1'b1;
    w0 = win1_cyc;
    run_pass(0, "t3", 1'b0, n0);
    chk("t3_win1_cycles", win1_cyc - w0, 4);
    force_stall[0] = 1'b0;

    // 5x5: poison the unread row/column with the maximum value
    fill_rand(1, 0, 254);
    for (int i = 0; i < 5; i++) begin
      mem[1][i * 5 + 4] = 8'sd127;
      mem[1][20 + i]    = 8'sd127;
    end
    lat_fix[1] = 1;
    run_pass(1, "t4", 1'b0, n0);
    chk("t4_unread_addr_hits", bad_addr, 0);

    // reset while waiting on the datapath for window 2
    fill_rand(0, 0, 255);
    lat_fix[0] = 3;
    p0 = ps_cnt[0];
    d0 = done_cnt[0];
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    cyc = 0;
    while (ps_cnt[0] < p0 + 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_reached_win2", ps_cnt[0] - p0, 3);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("t5_reset_outs", outs_nz(0), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_done", done_cnt[0] - d0, 0);
    chk("t5_stay_idle", int'(busy[0]), 0);
    run_pass(0, "t5_restart", 1'b0, n0);

    // pool_done in idle and start while busy are ignored
    @(negedge clk) noise[0] = 1'b1;
    @(negedge clk) noise[0] = 1'b0;
    @(negedge clk);
    chk("t6_noise_busy", int'(busy[0]), 0);
    chk("t6_noise_wr", int'(wr_en[0]), 0);
    fill_rand(0, 0, 255);
    run_pass(0, "t6", 1'b1, n0);

    // randomized passes with variable latency and write back-pressure
    for (int p = 0; p < 6; p++) begin
      int g;
      g = p % 2;
      fill_rand(g, 0, 255);
      lat_fix[g]   = 0;
      stall_pct[g] = 30;
      run_pass(g, "rnd", 1'b0, n0);
      stall_pct[g] = 0;
    end
    chk("rnd_unread_addr_hits", bad_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
